// File: rtl/ppu_clock_pkg.sv
// Shared constants and encodings for the SNES master clock (xin) generator.
package ppu_clock_pkg;

    localparam int unsigned COUNTER_WIDTH_DEF       = 32;
    localparam int unsigned DIV_BITS_DEF            = 8;
    localparam int unsigned DEFAULT_HALF_PERIOD_DEF = 5;
    localparam int unsigned BURST_BITS_DEF          = 16;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BURST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

endpackage

// File: rtl/ppu_clock_gen_if.sv
// Host-control and PPU-facing signal bundle of the xin clock generator.
interface ppu_clock_gen_if
    import ppu_clock_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEF,
    parameter int unsigned DIV_BITS      = DIV_BITS_DEF,
    parameter int unsigned BURST_BITS    = BURST_BITS_DEF
);
    logic [1:0]               mode_i;
    logic [DIV_BITS-1:0]      half_period_i;
    logic                     half_period_load_i;
    logic [BURST_BITS-1:0]    burst_count_i;
    logic                     burst_start_i;
    logic                     burst_busy_o;
    logic                     burst_done_o;
    logic                     counter_clear_i;
    logic                     xin_stall_i;
    logic                     xin_stall_o;
    logic                     xin;
    logic                     xin_rise_o;
    logic                     xin_fall_o;
    logic [COUNTER_WIDTH-1:0] xin_counter_o;

    modport master (
        output mode_i, half_period_i, half_period_load_i, burst_count_i,
               burst_start_i, counter_clear_i, xin_stall_i,
        input  burst_busy_o, burst_done_o, xin_stall_o, xin, xin_rise_o,
               xin_fall_o, xin_counter_o
    );

    modport slave (
        input  mode_i, half_period_i, half_period_load_i, burst_count_i,
               burst_start_i, counter_clear_i, xin_stall_i,
        output burst_busy_o, burst_done_o, xin_stall_o, xin, xin_rise_o,
               xin_fall_o, xin_counter_o
    );

endinterface

// File: rtl/ppu_clock_divider.sv
// Phase down-counter for xin: reloads from a shadow half-period at every edge,
// so a new half-period never truncates the phase in progress.
module ppu_clock_divider
    import ppu_clock_pkg::*;
#(
    parameter int unsigned DIV_BITS            = DIV_BITS_DEF,
    parameter int unsigned DEFAULT_HALF_PERIOD = DEFAULT_HALF_PERIOD_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DIV_BITS-1:0] half_period_i,
    input  logic                half_period_load_i,
    input  logic                reload_i,
    output logic                zero_o
);

    logic [DIV_BITS-1:0] shadow_q, shadow_d;
    logic [DIV_BITS-1:0] count_q,  count_d;

    // A half-period of 0 would mean no phase at all; it is held as 1.
    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (half_period_load_i) begin
            shadow_d = (half_period_i == '0) ? DIV_BITS'(1) : half_period_i;
        end
        if (reload_i) begin
            count_d = shadow_q - DIV_BITS'(1);
        end else if (count_q != '0) begin
            count_d = count_q - DIV_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow_q <= DIV_BITS'(DEFAULT_HALF_PERIOD);
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ppu_clock_gen.sv
// SNES master clock (xin) generator: programmable half-period, stop/run/burst
// modes, rise stall handshake, edge strobes and a falling-edge counter.
module ppu_clock_gen
    import ppu_clock_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH       = COUNTER_WIDTH_DEF,
    parameter int unsigned DIV_BITS            = DIV_BITS_DEF,
    parameter int unsigned DEFAULT_HALF_PERIOD = DEFAULT_HALF_PERIOD_DEF,
    parameter int unsigned BURST_BITS          = BURST_BITS_DEF
) (
    input  logic            clock,
    input  logic            reset,
    ppu_clock_gen_if.slave  bus
);

    phase_e                   phase_q,  phase_d;
    logic                     rise_q,   rise_d;
    logic                     fall_q,   fall_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;
    logic                     bphase_q, bphase_d;
    logic [COUNTER_WIDTH-1:0] cnt_q,    cnt_d;
    logic [BURST_BITS-1:0]    rem_q,    rem_d;

    logic div_zero;
    logic reload_c;
    logic go_c;
    logic start_c;

    ppu_clock_divider #(
        .DIV_BITS            (DIV_BITS),
        .DEFAULT_HALF_PERIOD (DEFAULT_HALF_PERIOD)
    ) u_divider (
        .clock              (clock),
        .reset              (reset),
        .half_period_i      (bus.half_period_i),
        .half_period_load_i (bus.half_period_load_i),
        .reload_i           (reload_c),
        .zero_o             (div_zero)
    );

    assign go_c    = (bus.mode_i == MODE_RUN) ||
                     ((bus.mode_i == MODE_BURST) && (rem_q != '0));
    assign start_c = bus.burst_start_i && (bus.mode_i == MODE_BURST) && !busy_q;

    // bphase marks a high phase opened by a burst; only its fall consumes the burst.
    always_comb begin
        phase_d  = phase_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        bphase_d = bphase_q;
        reload_c = 1'b0;

        case (phase_q)
            PH_LOW: begin
                if (div_zero && go_c && !bus.xin_stall_i) begin
                    phase_d  = PH_HIGH;
                    rise_d   = 1'b1;
                    reload_c = 1'b1;
                    bphase_d = (bus.mode_i == MODE_BURST);
                end
            end
            PH_HIGH: begin
                if (div_zero) begin
                    phase_d  = PH_LOW;
                    fall_d   = 1'b1;
                    reload_c = 1'b1;
                    bphase_d = 1'b0;
                    cnt_d    = cnt_q + COUNTER_WIDTH'(1);
                    if (bphase_q && (rem_q != '0)) begin
                        rem_d = rem_q - BURST_BITS'(1);
                        if (rem_q == BURST_BITS'(1)) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (start_c) begin
            rem_d  = bus.burst_count_i;
            busy_d = (bus.burst_count_i != '0);
            done_d = (bus.burst_count_i == '0);
        end

        if (bus.counter_clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_q  <= PH_LOW;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bphase_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bphase_q <= bphase_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.xin           = (phase_q == PH_HIGH);
    assign bus.xin_rise_o    = rise_q;
    assign bus.xin_fall_o    = fall_q;
    assign bus.burst_busy_o  = busy_q;
    assign bus.burst_done_o  = done_q;
    assign bus.xin_counter_o = cnt_q;
    assign bus.xin_stall_o   = bus.xin_stall_i && (phase_q == PH_LOW) && div_zero && go_c;

endmodule

// File: tb/tb_ppu_clock_gen.sv
// Bench for ppu_clock_gen: per-cycle comparison against a phase-age model plus
// scenario checks; counter is narrowed so wrap-around is reachable quickly.
module tb_ppu_clock_gen;
    import ppu_clock_pkg::*;

    localparam int unsigned CW    = 8;
    localparam int unsigned DB    = 8;
    localparam int unsigned BB    = 16;
    localparam int unsigned DEF_H = 5;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   s_stall;

    ppu_clock_gen_if #(.COUNTER_WIDTH(CW), .DIV_BITS(DB), .BURST_BITS(BB)) bus ();

    ppu_clock_gen #(
        .COUNTER_WIDTH(CW), .DIV_BITS(DB), .DEFAULT_HALF_PERIOD(DEF_H), .BURST_BITS(BB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: level of xin, cycles spent at that level, length owed to this phase.
    bit          m_xin = 0, m_rise = 0, m_fall = 0, m_busy = 0, m_done = 0, m_bphase = 0;
    int          m_age = 0, m_len = 0, m_shadow = DEF_H, m_rem = 0;
    logic [CW-1:0] m_cnt = '0;

    function automatic bit m_go();
        return (bus.mode_i == 2'd1) || ((bus.mode_i == 2'd2) && (m_rem != 0));
    endfunction

    task automatic tick();
        bit go, exp_stall, rise, fall, start;
        #2;
        go        = m_go();
        exp_stall = bus.xin_stall_i && !m_xin && (m_age >= m_len) && go;
        s_stall   = bus.xin_stall_o;
        checks++;
        if (bus.xin_stall_o !== exp_stall) begin
            errors++;
            $display("FAIL xin_stall_o: got %b expected %b at %0t", bus.xin_stall_o, exp_stall, $time);
        end
        @(posedge clock);
        if (!reset) begin
            m_xin = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_done = 0; m_bphase = 0;
            m_age = 0; m_len = 0; m_shadow = DEF_H; m_rem = 0; m_cnt = '0;
        end else begin
            rise  = !m_xin && (m_age >= m_len) && go && !bus.xin_stall_i;
            fall  = m_xin && (m_age >= m_len);
            start = bus.burst_start_i && (bus.mode_i == 2'd2) && !m_busy;
            m_rise = rise; m_fall = fall; m_done = 0;
            if (rise || fall) begin
                m_xin = rise; m_age = 1; m_len = m_shadow;
            end else if (m_age < 1000000) begin
                m_age++;
            end
            if (fall) begin
                m_cnt = m_cnt + CW'(1);
                if (m_bphase) begin
                    m_rem--;
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                end
                m_bphase = 0;
            end
            if (rise) m_bphase = (bus.mode_i == 2'd2);
            if (start) begin
                m_rem = int'(bus.burst_count_i); m_busy = (m_rem != 0); m_done = (m_rem == 0);
            end
            if (bus.counter_clear_i) m_cnt = '0;
            if (bus.half_period_load_i) m_shadow = (bus.half_period_i == '0) ? 1 : int'(bus.half_period_i);
        end
        #1;
        checks++; if (bus.xin !== m_xin) begin errors++; $display("FAIL xin: got %b expected %b at %0t", bus.xin, m_xin, $time); end
        checks++; if (bus.xin_rise_o !== m_rise) begin errors++; $display("FAIL xin_rise_o: got %b expected %b at %0t", bus.xin_rise_o, m_rise, $time); end
        checks++; if (bus.xin_fall_o !== m_fall) begin errors++; $display("FAIL xin_fall_o: got %b expected %b at %0t", bus.xin_fall_o, m_fall, $time); end
        checks++; if (bus.burst_busy_o !== m_busy) begin errors++; $display("FAIL burst_busy_o: got %b expected %b at %0t", bus.burst_busy_o, m_busy, $time); end
        checks++; if (bus.burst_done_o !== m_done) begin errors++; $display("FAIL burst_done_o: got %b expected %b at %0t", bus.burst_done_o, m_done, $time); end
        checks++; if (bus.xin_counter_o !== m_cnt) begin errors++; $display("FAIL xin_counter_o: got %0h expected %0h at %0t", bus.xin_counter_o, m_cnt, $time); end
    endtask

    task automatic wait_rise(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.xin_rise_o) begin ok = 1; break; end
        end
        if (!ok) begin checks++; errors++; $display("FAIL wait_rise: no rise within %0d cycles", budget); end
    endtask

    // Advance until the model says a fall is due with the counter at the given value.
    task automatic wait_fall_at(input logic [CW-1:0] value, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_cnt == value && m_xin && m_age >= m_len) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin checks++; errors++; $display("FAIL wait_fall_at: counter %0h not reached", value); end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) tick();
        checks++;
        if ({bus.xin, bus.xin_rise_o, bus.xin_fall_o, bus.burst_busy_o, bus.burst_done_o} !== 5'b0 ||
            bus.xin_counter_o !== '0) begin
            errors++;
            $display("FAIL reset_state: got xin=%b cnt=%0h expected all zero", bus.xin, bus.xin_counter_o);
        end
        reset = 1;
    endtask

    task automatic test_run();
        int n_rise, n_fall;
        reset = 0; bus.mode_i = MODE_RUN; tick(); reset = 1;
        tick();
        checks++; if (bus.xin !== 1'b1) begin errors++; $display("FAIL run_first_rise: got %b expected 1", bus.xin); end
        n_rise = 1; n_fall = 0;
        repeat (29) begin tick(); n_rise += int'(bus.xin_rise_o); n_fall += int'(bus.xin_fall_o); end
        checks++; if (bus.xin_counter_o !== CW'(3)) begin errors++; $display("FAIL run_count30: got %0d expected 3", bus.xin_counter_o); end
        checks++; if (n_rise != 3 || n_fall != 3) begin errors++; $display("FAIL run_strobes: got rise=%0d fall=%0d expected 3/3", n_rise, n_fall); end
    endtask

    task automatic test_half_period_load();
        logic [10:0] got, exp;
        bus.mode_i = MODE_RUN;
        wait_rise(40);
        got = '0; got[10] = bus.xin;
        bus.half_period_i = DB'(2); bus.half_period_load_i = 1; tick(); bus.half_period_load_i = 0;
        got[9] = bus.xin;
        for (int i = 2; i < 11; i++) begin tick(); got[10-i] = bus.xin; end
        exp = 11'b11111_00_11_00;
        checks++; if (got !== exp) begin errors++; $display("FAIL hp_load_shape: got %b expected %b", got, exp); end
    endtask

    task automatic test_stall();
        int n_st, n_hi;
        bit ok;
        bus.mode_i = MODE_RUN;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (!m_xin && m_age >= m_len) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin checks++; errors++; $display("FAIL stall_setup: rise never due"); end
        n_st = 0; n_hi = 0;
        bus.xin_stall_i = 1;
        repeat (7) begin tick(); n_st += int'(s_stall); n_hi += int'(bus.xin); end
        bus.xin_stall_i = 0;
        tick();
        checks++; if (n_st != 7) begin errors++; $display("FAIL stall_cycles: got %0d expected 7", n_st); end
        checks++; if (n_hi != 0) begin errors++; $display("FAIL stall_hold: got %0d high cycles expected 0", n_hi); end
        checks++; if (bus.xin !== 1'b1) begin errors++; $display("FAIL stall_release: got xin=%b expected 1", bus.xin); end
    endtask

    task automatic test_burst();
        int n_rise, n_done, n_bad;
        logic [CW-1:0] cnt0;
        bus.mode_i = MODE_STOP;
        repeat (12) tick();
        bus.half_period_i = DB'(3); bus.half_period_load_i = 1; tick(); bus.half_period_load_i = 0;
        cnt0 = m_cnt;
        bus.mode_i = MODE_BURST; bus.burst_count_i = BB'(3); bus.burst_start_i = 1; tick(); bus.burst_start_i = 0;
        checks++; if (bus.burst_busy_o !== 1'b1) begin errors++; $display("FAIL burst_busy_set: got %b expected 1", bus.burst_busy_o); end
        n_rise = 0; n_done = 0; n_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin bus.burst_count_i = BB'(9); bus.burst_start_i = 1; end
            tick();
            bus.burst_start_i = 0;
            n_rise += int'(bus.xin_rise_o);
            if (bus.burst_done_o) begin n_done++; if (!bus.xin_fall_o) n_bad++; end
        end
        checks++; if (n_rise != 3) begin errors++; $display("FAIL burst_rises: got %0d expected 3", n_rise); end
        checks++; if (n_done != 1 || n_bad != 0) begin errors++; $display("FAIL burst_done: got %0d pulses (%0d off-fall) expected 1 (0)", n_done, n_bad); end
        checks++; if (bus.burst_busy_o !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b expected 0", bus.burst_busy_o); end
        checks++; if (bus.xin_counter_o !== CW'(cnt0 + CW'(3))) begin errors++; $display("FAIL burst_count: got %0d expected %0d", bus.xin_counter_o, CW'(cnt0 + CW'(3))); end
    endtask

    task automatic test_burst_zero();
        int n_edges;
        bus.mode_i = MODE_BURST; bus.burst_count_i = '0; bus.burst_start_i = 1; tick(); bus.burst_start_i = 0;
        checks++; if (bus.burst_done_o !== 1'b1 || bus.burst_busy_o !== 1'b0) begin errors++; $display("FAIL burst0_done: got done=%b busy=%b expected 1/0", bus.burst_done_o, bus.burst_busy_o); end
        tick();
        checks++; if (bus.burst_done_o !== 1'b0) begin errors++; $display("FAIL burst0_pulse: got done=%b expected 0", bus.burst_done_o); end
        n_edges = 0;
        repeat (10) begin tick(); n_edges += int'(bus.xin_rise_o) + int'(bus.xin_fall_o); end
        checks++; if (n_edges != 0) begin errors++; $display("FAIL burst0_edges: got %0d expected 0", n_edges); end
    endtask

    task automatic test_stop_mid_high();
        int n_hi, n_rise;
        bus.mode_i = MODE_RUN;
        wait_rise(40);
        n_hi = 1;
        bus.mode_i = MODE_STOP;
        for (int i = 0; i < 20; i++) begin tick(); if (bus.xin) n_hi++; else break; end
        n_rise = 0;
        repeat (20) begin tick(); n_rise += int'(bus.xin_rise_o); end
        checks++; if (n_hi != 3) begin errors++; $display("FAIL stop_high_len: got %0d expected 3", n_hi); end
        checks++; if (n_rise != 0) begin errors++; $display("FAIL stop_no_rise: got %0d expected 0", n_rise); end
    endtask

    task automatic test_wrap_clear();
        bus.mode_i = MODE_RUN;
        bus.half_period_i = DB'(1); bus.half_period_load_i = 1; tick(); bus.half_period_load_i = 0;
        wait_fall_at(CMAX, 1500);
        tick();
        checks++; if (bus.xin_counter_o !== '0 || bus.xin_fall_o !== 1'b1) begin errors++; $display("FAIL wrap: got cnt=%0h fall=%b expected 0/1", bus.xin_counter_o, bus.xin_fall_o); end
        wait_fall_at(CW'(5), 40);
        bus.counter_clear_i = 1; tick(); bus.counter_clear_i = 0;
        checks++; if (bus.xin_counter_o !== '0) begin errors++; $display("FAIL clear_vs_fall: got %0h expected 0", bus.xin_counter_o); end
        wait_fall_at(CMAX, 1500);
        bus.counter_clear_i = 1; tick(); bus.counter_clear_i = 0;
        checks++; if (bus.xin_counter_o !== '0) begin errors++; $display("FAIL clear_at_max: got %0h expected 0", bus.xin_counter_o); end
    endtask

    task automatic test_reset_mid_high();
        bus.mode_i = MODE_RUN;
        bus.half_period_i = DB'(4); bus.half_period_load_i = 1; tick(); bus.half_period_load_i = 0;
        wait_rise(40);
        tick();
        reset = 0; tick(); reset = 1;
        checks++;
        if ({bus.xin, bus.xin_rise_o, bus.xin_fall_o, bus.burst_busy_o, bus.burst_done_o} !== 5'b0 ||
            bus.xin_counter_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_high: got xin=%b fall=%b cnt=%0h expected all zero", bus.xin, bus.xin_fall_o, bus.xin_counter_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.mode_i = 2'($urandom_range(0, 3));
            bus.half_period_load_i = ($urandom_range(0, 29) == 0);
            bus.half_period_i      = DB'($urandom_range(0, 6));
            bus.burst_start_i      = ($urandom_range(0, 7) == 0);
            bus.burst_count_i      = BB'($urandom_range(0, 4));
            bus.counter_clear_i    = ($urandom_range(0, 39) == 0);
            bus.xin_stall_i        = ($urandom_range(0, 3) == 0);
            reset                  = ($urandom_range(0, 499) != 0);
            tick();
        end
        bus.half_period_load_i = 0; bus.burst_start_i = 0; bus.counter_clear_i = 0;
        bus.xin_stall_i = 0; reset = 1;
    endtask

    initial begin
        bus.mode_i = MODE_STOP; bus.half_period_i = '0; bus.half_period_load_i = 0;
        bus.burst_count_i = '0; bus.burst_start_i = 0; bus.counter_clear_i = 0; bus.xin_stall_i = 0;
        test_reset();
        test_run();
        test_half_period_load();
        test_stall();
        test_burst();
        test_burst_zero();
        test_stop_mid_high();
        test_wrap_clear();
        test_reset_mid_high();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ppu_clock_gen.md
Name: ppu_clock_gen

Overview:
Parametrised generator for the SNES master clock (xin) driven from the FPGA system clock. It provides a runtime-programmable half-period, and three modes: stopped, free-run, and burst of N xin cycles with busy/done status. It also keeps the stall handshake, single-cycle edge strobes and a clearable falling-edge counter. It sits between the host control logic and the PPU-facing pins and replaces the fixed-divider clock block.

Parameters:
COUNTER_WIDTH, 32, width of xin_counter_o
DIV_BITS, 8, width of the half-period setting
DEFAULT_HALF_PERIOD, 5, half-period in system clocks after reset (12MHz → 1.2MHz)
BURST_BITS, 16, width of the burst length

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
mode_i  in  2  0=STOP, 1=RUN, 2=BURST, 3=reserved (treated as STOP)
half_period_i  in  DIV_BITS  new half-period in system clocks
half_period_load_i  in  1  latch half_period_i into the shadow register
burst_count_i  in  BURST_BITS  number of xin cycles for a burst
burst_start_i  in  1  start a burst (honoured only in BURST mode when not busy)
burst_busy_o  out  1  burst in progress
burst_done_o  out  1  one-cycle pulse when a burst completes
counter_clear_i  in  1  zero xin_counter_o
xin_stall_i  in  1  hold off the next rising edge
xin_stall_o  out  1  high while the stall is actually blocking a due rise
xin  out  1  master clock, registered
xin_rise_o  out  1  pulse in the first cycle xin is high
xin_fall_o  out  1  pulse in the first cycle xin is low after a high phase
xin_counter_o  out  COUNTER_WIDTH  count of completed xin cycles

Behaviour:
- Reset values (reset==0 at a clock edge):
  - xin, xin_rise_o, xin_fall_o, burst_busy_o, burst_done_o, xin_counter_o = 0
  - div_count = 0, burst_remaining = 0
  - active half-period H = DEFAULT_HALF_PERIOD
  - Reset mid-high forces xin low immediately; no fall strobe and no count.
- Half-period:
  - half_period_load_i captures the value into a shadow register. The shadow is copied into H only when div_count is reloaded (at each edge), so a phase is never truncated.
  - A loaded value of 0 is stored as 1.
- Divider: at every edge div_count <= H-1, then it decrements to 0. This gives exactly H cycles high and H cycles low per phase; period is 2H when unstalled.
- Permission `go` is true when either:
  - mode==RUN, or
  - mode==BURST and burst_remaining!=0.
- Rise: when xin==0, div_count==0, go and !xin_stall_i:
  - xin <= 1, xin_rise_o <= 1, reload div_count.
  - Otherwise xin stays low and div_count stays 0; the rise is taken the first cycle the condition holds.
- Fall: when xin==1 and div_count==0:
  - xin <= 0, xin_fall_o <= 1, xin_counter_o += 1 (wraps modulo 2^COUNTER_WIDTH), reload div_count.
  - A high phase always completes, even if the mode changes to STOP or the block stalls; xin never has a runt pulse.
- xin_stall_o = xin_stall_i & ~xin & (div_count==0) & go. This is combinational.
- counter_clear_i forces the counter to 0. If it coincides with a fall, clear wins and the result is 0.
- Burst:
  - burst_start_i with mode==BURST and !burst_busy_o loads burst_remaining = burst_count_i and sets busy next cycle.
  - Each fall decrements burst_remaining.
  - On the fall that reaches 0: busy <= 0 and burst_done_o <= 1, both in the same cycle as xin_fall_o.
  - burst_count_i==0: no edges; done pulses one cycle after the start and busy never asserts.
  - Start while busy is ignored.
  - Leaving BURST mode mid-burst: the current high phase finishes, then edges stop. burst_remaining is held; re-entering BURST resumes it.

Decomposition:
- Package ppu_clock_pkg holds:
  - mode encodings MODE_STOP/MODE_RUN/MODE_BURST
  - the default parameter constants
- Sub-module ppu_clock_divider holds the down-counter with shadow reload, the zero flag and the "treat 0 as 1" rule.
- The FSM, burst and counter logic stay in ppu_clock_gen.

Test Plan:
- Reset, mode=RUN, H=5, no stall → xin rises in cycle 1, then holds 5 high / 5 low; xin_counter_o=3 after 30 cycles; each edge has exactly one rise/fall strobe.
- Load H=2 mid-high while H=5 → the current high phase lasts 5 cycles, then the low phase is 2 and the period becomes 4.
- RUN, assert xin_stall_i for 7 cycles when a rise is due → xin_stall_o high 7 cycles, xin stays low, then rises the cycle after the stall drops.
- BURST, burst_count_i=3, start → exactly 3 rises; burst_done_o pulses with the 3rd xin_fall_o; busy low afterwards; counter +3. A start issued while busy is ignored.
- burst_count_i=0 → done pulses one cycle after the start, no xin edges. Mode→STOP during a high phase → the high phase completes at H cycles, then no further rise.
- counter_clear_i coincident with a fall at counter=0xFFFFFFFF → counter 0. Separately, fall at 0xFFFFFFFF with no clear → wraps to 0. Reset asserted mid-high → xin=0 next cycle, all outputs at reset values.
